// File: rtl/my_nco_pkg.sv
// Shared types and constants for the NCO phase detector (CORDIC vectoring).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state type, atan(2^-k) table at 2^32 per turn for k=0..15,
// and a helper that rescales a table entry to any phase word width.
package my_nco_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREROT = 2'd1,
    ITER   = 2'd2,
    DONE   = 2'd3
  } nco_state_t;

  localparam int ATAN_N = 16;

  // Fraction bits carried below the phase LSB inside the angle accumulator,
  // so that rounding of the table entries does not pile up over iterations.
  localparam int GUARD_W = 4;

  // atan(2^-k) / (2*pi) * 2^32, rounded.
  localparam logic [31:0] ATAN_TAB [ATAN_N] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

  // Table entry k rescaled (with rounding) to a w-bit-per-turn angle word.
  function automatic logic [31:0] atan_lut(input logic [3:0] k, input int w);
    logic [32:0] t;
    if (w >= 32) return ATAN_TAB[k];
    t = {1'b0, ATAN_TAB[k]} + (33'd1 << (31 - w));
    return 32'(t >> (32 - w));
  endfunction

endpackage

// File: rtl/my_nco_cordic_stage.sv
// One CORDIC vectoring micro-rotation, purely combinational.
// Latency: 0 cycles.
// Backpressure: none; the caller decides when to register the result.
//
// Ports: x_i/y_i signed vector, z_i accumulated angle, k_i iteration index;
//        x_o/y_o/z_o rotated vector and updated angle.
module my_nco_cordic_stage
  import my_nco_pkg::*;
#(
  parameter int xw = 16,
  parameter int zw = 20
) (
  input  logic signed [xw-1:0] x_i,
  input  logic signed [xw-1:0] y_i,
  input  logic        [zw-1:0] z_i,
  input  logic        [3:0]    k_i,
  output logic signed [xw-1:0] x_o,
  output logic signed [xw-1:0] y_o,
  output logic        [zw-1:0] z_o
);

  logic signed [xw-1:0] x_sh;
  logic signed [xw-1:0] y_sh;
  logic        [zw-1:0] ang;

  always_comb begin
    x_sh = x_i >>> k_i;
    y_sh = y_i >>> k_i;
    ang  = zw'(atan_lut(k_i, zw));
    // Rotate toward y=0; the angle accumulator wraps naturally at 2^zw.
    if (!y_i[xw-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + ang;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - ang;
    end
  end

endmodule

// File: rtl/my_nco_phase_det.sv
// Recovers phase (atan2) of a sin/cos sample pair and the phase step between samples.
// Latency: niter+2 enabled cycles from acceptance to out_valid; one sample per niter+3.
// Backpressure: in_ready high only in IDLE; no input buffering, in_valid ignored while busy.
//
// Ports: clk, reset_n (async, active-low), clken (global hold), in_valid/in_ready,
//        fsin_i/fcos_i (mpr-bit signed), phase_o/freq_o (aprp-bit, full word = one turn),
//        out_valid (result pulse), freq_valid (out_valid once a previous phase exists).
module my_nco_phase_det
  import my_nco_pkg::*;
#(
  parameter int mpr   = 14,
  parameter int aprp  = 16,
  parameter int niter = 14   // valid range 8..aprp-2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [mpr-1:0]  fsin_i,
  input  logic [mpr-1:0]  fcos_i,
  output logic [aprp-1:0] phase_o,
  output logic [aprp-1:0] freq_o,
  output logic            out_valid,
  output logic            freq_valid
);

  localparam int XW = mpr + 2;
  localparam int GW = GUARD_W;
  localparam int ZW = aprp + GW;

  localparam logic [ZW-1:0] Z_HALF_TURN = ZW'(1) << (ZW - 1);
  localparam logic [ZW-1:0] Z_RND       = ZW'(1) << (GW - 1);
  localparam logic [3:0]    K_LAST      = 4'(niter - 1);

  nco_state_t state_q, state_d;
  logic [3:0]           k_q, k_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic [ZW-1:0]        z_q, z_d;
  logic                 zero_q, zero_d;
  logic [aprp-1:0]      phase_q, phase_d;
  logic [aprp-1:0]      freq_q, freq_d;
  logic [aprp-1:0]      prev_q, prev_d;
  logic                 have_prev_q, have_prev_d;
  logic                 out_valid_q, out_valid_d;
  logic                 freq_valid_q, freq_valid_d;

  logic signed [XW-1:0] x_nxt;
  logic signed [XW-1:0] y_nxt;
  logic [ZW-1:0]        z_nxt;
  logic [aprp-1:0]      phase_rnd;

  my_nco_cordic_stage #(
    .xw (XW),
    .zw (ZW)
  ) u_stage (
    .x_i (x_q),
    .y_i (y_q),
    .z_i (z_q),
    .k_i (k_q),
    .x_o (x_nxt),
    .y_o (y_nxt),
    .z_o (z_nxt)
  );

  // Drop the guard bits with round-to-nearest; wraps modulo one turn.
  assign phase_rnd = aprp'((z_q + Z_RND) >> GW);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    zero_d       = zero_q;
    phase_d      = phase_q;
    freq_d       = freq_q;
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    out_valid_d  = out_valid_q;
    freq_valid_d = freq_valid_q;

    if (clken) begin
      out_valid_d  = 1'b0;
      freq_valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Widen before any negation so the most negative input survives.
            x_d     = {{2{fcos_i[mpr-1]}}, fcos_i};
            y_d     = {{2{fsin_i[mpr-1]}}, fsin_i};
            // A (0,0) vector has no angle; report 0 instead of the CORDIC residue.
            zero_d  = (fcos_i == '0) && (fsin_i == '0);
            state_d = PREROT;
          end
        end
        PREROT: begin
          // Fold the left half-plane onto the right so the iterations converge.
          if (x_q[XW-1]) begin
            x_d = -x_q;
            y_d = -y_q;
            z_d = Z_HALF_TURN;
          end else begin
            z_d = '0;
          end
          k_d     = '0;
          state_d = ITER;
        end
        ITER: begin
          x_d = x_nxt;
          y_d = y_nxt;
          z_d = z_nxt;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
        DONE: begin
          phase_d      = zero_q ? '0 : phase_rnd;
          freq_d       = phase_d - prev_q;
          prev_d       = phase_d;
          out_valid_d  = 1'b1;
          freq_valid_d = have_prev_q;
          have_prev_d  = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      zero_q       <= 1'b0;
      phase_q      <= '0;
      freq_q       <= '0;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      zero_q       <= zero_d;
      phase_q      <= phase_d;
      freq_q       <= freq_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      out_valid_q  <= out_valid_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign phase_o    = phase_q;
  assign freq_o     = freq_q;
  assign out_valid  = out_valid_q;
  assign freq_valid = freq_valid_q;

endmodule

// File: tb/tb_my_nco_phase_det.sv
// Directed bench for my_nco_phase_det: known angles, latency, stall, throughput, reset abort, phase-step series.
// Latency: n/a.
// Backpressure: n/a.
module tb_my_nco_phase_det;

  logic        clk;
  logic        reset_n;
  logic        clken;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] fsin_i;
  logic [13:0] fcos_i;
  logic [15:0] phase_o;
  logic [15:0] freq_o;
  logic        out_valid;
  logic        freq_valid;

  int n_cmp = 0;
  int n_err = 0;

  my_nco_phase_det #(
    .mpr   (14),
    .aprp  (16),
    .niter (14)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clken      (clken),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fsin_i     (fsin_i),
    .fcos_i     (fcos_i),
    .phase_o    (phase_o),
    .freq_o     (freq_o),
    .out_valid  (out_valid),
    .freq_valid (freq_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Circular distance check on a 16-bit phase word.
  task automatic chk_near(input string tag, input logic [15:0] obs, input logic [15:0] exp, input int tol);
    logic signed [15:0] d;
    int ad;
    d  = obs - exp;
    ad = (d < 0) ? -int'(d) : int'(d);
    n_cmp++;
    assert (ad <= tol) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Offer one sample from IDLE, optionally drop clken for stall_len cycles
  // starting stall_at cycles after acceptance, and wait for the result.
  task automatic do_conv(input int s, input int c, input int stall_at, input int stall_len,
                         output int lat, output logic [15:0] ph, output logic [15:0] fq,
                         output logic fv);
    int n;
    chk("in_ready_before_accept", in_ready, 1);
    fsin_i   = 14'(s);
    fcos_i   = 14'(c);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fsin_i   = '0;
    fcos_i   = '0;
    n   = 0;
    lat = -1;
    while (n < 100 && lat < 0) begin
      if (n == stall_at) clken = 1'b0;
      if (n == stall_at + stall_len) clken = 1'b1;
      @(posedge clk); #1;
      n++;
      if (out_valid) lat = n;
    end
    clken = 1'b1;
    chk("out_valid_seen", out_valid, 1);
    ph = phase_o;
    fq = freq_o;
    fv = freq_valid;
    @(posedge clk); #1;
    chk("out_valid_one_cycle", out_valid, 0);
  endtask

  initial begin
    int          lat;
    logic [15:0] ph;
    logic [15:0] fq;
    logic        fv;
    int          cnt;
    int          ovc;

    reset_n  = 1'b0;
    clken    = 1'b1;
    in_valid = 1'b0;
    fsin_i   = '0;
    fcos_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_phase", phase_o, 0);
    chk("rst_freq", freq_o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_freq_valid", freq_valid, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 0 degrees: latency and first-result freq_valid.
    do_conv(0, 8191, -1, 0, lat, ph, fq, fv);
    chk("lat_0deg", lat, 16);
    chk_near("phase_0deg", ph, 16'h0000, 2);
    chk("fv_first", fv, 0);

    do_conv(8191, 0, -1, 0, lat, ph, fq, fv);
    chk_near("phase_90deg", ph, 16'h4000, 2);
    chk("fv_second", fv, 1);
    chk_near("freq_90deg", fq, 16'h4000, 4);

    do_conv(0, -8191, -1, 0, lat, ph, fq, fv);
    chk_near("phase_180deg", ph, 16'h8000, 2);
    chk_near("freq_180deg", fq, 16'h4000, 4);

    do_conv(-5792, 5792, -1, 0, lat, ph, fq, fv);
    chk_near("phase_315deg", ph, 16'hE000, 2);

    do_conv(-8192, -8192, -1, 0, lat, ph, fq, fv);
    chk_near("phase_225deg_fullscale", ph, 16'hA000, 2);
    chk_near("freq_225deg", fq, 16'hC000, 4);

    do_conv(0, 0, -1, 0, lat, ph, fq, fv);
    chk("phase_zero_vec", ph, 16'h0000);
    chk("hold_phase_after", phase_o, 16'h0000);

    // Five disabled cycles inside ITER push the result out by exactly five.
    do_conv(8191, 0, 5, 5, lat, ph, fq, fv);
    chk("lat_stall", lat, 21);
    chk_near("phase_stall", ph, 16'h4000, 2);
    chk_near("hold_phase_idle", phase_o, 16'h4000, 2);

    // in_valid held high: busy window of 16 cycles, then a new acceptance.
    fsin_i   = 14'(0);
    fcos_i   = 14'(8191);
    in_valid = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", cnt, 16);
    chk("busy_end_out_valid", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second_accept", in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("b2b_latency", cnt, 16);
    chk_near("b2b_phase", phase_o, 16'h0000, 2);
    @(posedge clk); #1;

    // Reset pulse while ITER is at k=7 aborts the conversion.
    fsin_i   = 14'(8191);
    fcos_i   = 14'(0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_phase", phase_o, 0);
    chk("abort_freq", freq_o, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_freq_valid", freq_valid, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ovc = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) ovc++;
    end
    chk("abort_no_out_valid", ovc, 0);

    // Phase-step series 0x1000 starting at 0xF000, wrapping through zero.
    for (int i = 0; i < 10; i++) begin
      int    p;
      real   a;
      real   sr;
      real   cr;
      int    si;
      int    ci;
      p  = (16'hF000 + i * 16'h1000) % 65536;
      a  = 6.283185307179586 * p / 65536.0;
      sr = 8000.0 * $sin(a);
      cr = 8000.0 * $cos(a);
      si = $rtoi(sr + ((sr >= 0.0) ? 0.5 : -0.5));
      ci = $rtoi(cr + ((cr >= 0.0) ? 0.5 : -0.5));
      do_conv(si, ci, -1, 0, lat, ph, fq, fv);
      chk_near($sformatf("series_phase_%0d", i), ph, 16'(p), 2);
      if (i == 0) begin
        chk("series_fv_first", fv, 0);
      end else begin
        chk($sformatf("series_fv_%0d", i), fv, 1);
        chk_near($sformatf("series_freq_%0d", i), fq, 16'h1000, 4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
